alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 5, register address width; DATA_WIDTH, 32, operand/result width.
REQ-002 SHALL have ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- req_valid_i  in  2  per-requester command valid; bit n = requester n
- req_ready_o  out  2  per-requester command accepted
- req_rs1_i, req_rs2_i, req_rd_i  in  2x ADDR_WIDTH  per-requester register addresses
- req_imm_i  in  2x DATA_WIDTH  per-requester immediate
- req_alu_src_i  in  2  per-requester ALU operand-2 select (1 = imm)
- req_alu_ctrl_i  in  2x4  per-requester ALU operation
- req_reg_write_i  in  2  per-requester write-back enable
- dp_rs1_o, dp_rs2_o, dp_rd_o  out  ADDR_WIDTH  to datapath
- dp_imm_o  out  DATA_WIDTH  to datapath
- dp_alu_src_o  out  1  to datapath
- dp_alu_ctrl_o  out  4  to datapath
- dp_reg_write_o  out  1  datapath register write enable
- dp_reg_write_src_o  out  1  write-back source; always 0 (ALU)
- dp_alu_out_i  in  DATA_WIDTH  datapath ALU result
- dp_eq_i  in  1  datapath equal flag
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed
- resp_id_o  out  1  requester owning the response
- resp_data_o  out  DATA_WIDTH  captured ALU result
- resp_eq_o  out  1  captured equal flag

Function
REQ-003 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-004 IDLE: req_ready_o one-hot to the granted requester when any req_valid_i is high, else 0; valid&ready latches the granted command into a command register and moves to EXEC the next cycle.
REQ-005 req_ready_o SHALL be 0 in EXEC and RESP.
REQ-006 EXEC lasts exactly one cycle: dp_* driven from the command register; dp_reg_write_o = latched reg_write; dp_alu_out_i and dp_eq_i captured into the response register at the end of the cycle; next state RESP.
REQ-007 Outside EXEC, dp_reg_write_o SHALL be 0 and dp_* SHALL hold the command register value.
REQ-008 RESP: resp_valid_o = 1 with stable resp_id_o/resp_data_o/resp_eq_o until resp_ready_i; on resp_valid_o & resp_ready_i return to IDLE.
REQ-009 Latency: accept at cycle N, register write at clock edge ending N+1, resp_valid_o at N+2; minimum issue interval 3 cycles.
REQ-010 Both valid in IDLE: grant per REQ-014; loser keeps valid with ready 0 and SHALL NOT be dropped.
REQ-011 resp_ready_i high outside RESP SHALL have no effect.

Reset
REQ-012 rst_i high at a clock edge SHALL force IDLE, req_ready_o=0 for that cycle, resp_valid_o=0, dp_reg_write_o=0, command/response registers=0, priority pointer=requester 0.
REQ-013 Reset during EXEC SHALL suppress the write-back (dp_reg_write_o low from that edge) and discard the in-flight command and response.

Configuration
REQ-014 With ALU_ARB_ROUND_ROBIN_EN defined: round-robin; a 1-bit pointer names the preferred requester and after each accept points to the other requester. Without it: fixed priority, requester 0 always wins, no pointer register.

Structure
REQ-015 Package alu_arb_pkg SHALL hold the FSM state enum, the command struct (rs1, rs2, rd, imm, alu_src, alu_ctrl, reg_write, id) and NUM_REQ = 2.
REQ-016 Grant selection SHALL be a combinational sub-module alu_arb_pick (valid vector, pointer -> one-hot grant).

Verification
REQ-017 Reset: rst_i high 2 cycles with both valid -> req_ready_o=00, resp_valid_o=0, dp_reg_write_o=0 throughout.
REQ-018 Single request: req0 add x1=5,x2=7 -> x3, ready at N, dp_reg_write_o=1 only at N+1, resp_valid_o at N+2, resp_data_o=12, resp_id_o=0, regfile x3=12.
REQ-019 Contention, RR on: both valid continuously for 4 ops -> grant order 0,1,0,1; RR off -> 0,0,0,0 with req1 ready never high.
REQ-020 Back-pressure: resp_ready_i low 5 cycles in RESP -> resp outputs stable, req_ready_o=00, no second write; release -> IDLE next cycle.
REQ-021 Reset in EXEC: rst_i at N+1 with reg_write=1 -> destination register unchanged, resp_valid_o never asserted.
REQ-022 Equal flag: sub x4=9,x5=9, reg_write=0 -> resp_eq_o=1, resp_data_o=0, dp_reg_write_o never high.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state encoding, the latched command format and the
// requester count used by alu_arbiter and alu_arb_pick.
// The command struct is sized by ARB_ADDR_WIDTH / ARB_DATA_WIDTH, which are
// also the defaults of the top-level ADDR_WIDTH / DATA_WIDTH parameters.
package alu_arb_pkg;

    localparam int NUM_REQ        = 2;
    localparam int ARB_ADDR_WIDTH = 5;
    localparam int ARB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [ARB_ADDR_WIDTH-1:0] rs1;
        logic [ARB_ADDR_WIDTH-1:0] rs2;
        logic [ARB_ADDR_WIDTH-1:0] rd;
        logic [ARB_DATA_WIDTH-1:0] imm;
        logic                      alu_src;
        logic [3:0]                alu_ctrl;
        logic                      reg_write;
        logic                      id;
    } cmd_t;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational grant selector.
// Ports:
//   valid - per-requester request vector
//   ptr   - preferred requester index (tie-break winner)
//   grant - one-hot grant, all zero when nothing is valid
module alu_arb_pick
    import alu_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (valid[ptr]) begin
            grant[ptr] = 1'b1;
        end else if (valid[~ptr]) begin
            grant[~ptr] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two command requesters onto a single ALU datapath.
// One command at a time: IDLE (grant/accept) -> EXEC (one cycle, datapath
// driven, result captured) -> RESP (held until consumed) -> IDLE.
// Ports:
//   clk_i, rst_i           - clock, synchronous active-high reset
//   req_*_i / req_ready_o  - per-requester command channel (flattened, n-th
//                            slice belongs to requester n)
//   dp_*_o / dp_*_i        - datapath control out, ALU result/equal flag in
//   resp_*                 - response channel with valid/ready handshake
// Build option: ALU_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it requester 0 always has priority.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rs1_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rs2_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_imm_i,
    input  logic [NUM_REQ-1:0]            req_alu_src_i,
    input  logic [NUM_REQ*4-1:0]          req_alu_ctrl_i,
    input  logic [NUM_REQ-1:0]            req_reg_write_i,
    output logic [ADDR_WIDTH-1:0]         dp_rs1_o,
    output logic [ADDR_WIDTH-1:0]         dp_rs2_o,
    output logic [ADDR_WIDTH-1:0]         dp_rd_o,
    output logic [DATA_WIDTH-1:0]         dp_imm_o,
    output logic                          dp_alu_src_o,
    output logic [3:0]                    dp_alu_ctrl_o,
    output logic                          dp_reg_write_o,
    output logic                          dp_reg_write_src_o,
    input  logic [DATA_WIDTH-1:0]         dp_alu_out_i,
    input  logic                          dp_eq_i,
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output logic                          resp_id_o,
    output logic [DATA_WIDTH-1:0]         resp_data_o,
    output logic                          resp_eq_o
);

    state_t                state_reg, state_next;
    cmd_t                  cmd_reg, cmd_next;
    cmd_t                  req_cmd [NUM_REQ];
    logic [DATA_WIDTH-1:0] resp_data_reg;
    logic                  resp_eq_reg;
    logic [NUM_REQ-1:0]    grant;
    logic                  ptr_sel;
    logic                  accept;

    // Unpack the flattened request buses into one command per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_cmd[gi] = '{
                rs1:       req_rs1_i[gi*ADDR_WIDTH +: ADDR_WIDTH],
                rs2:       req_rs2_i[gi*ADDR_WIDTH +: ADDR_WIDTH],
                rd:        req_rd_i[gi*ADDR_WIDTH +: ADDR_WIDTH],
                imm:       req_imm_i[gi*DATA_WIDTH +: DATA_WIDTH],
                alu_src:   req_alu_src_i[gi],
                alu_ctrl:  req_alu_ctrl_i[gi*4 +: 4],
                reg_write: req_reg_write_i[gi],
                id:        1'(gi)
            };
        end
    endgenerate

    alu_arb_pick u_pick (
        .valid (req_valid_i),
        .ptr   (ptr_sel),
        .grant (grant)
    );

    // With two requesters the upper grant bit is the winner's index.
    assign cmd_next = req_cmd[grant[NUM_REQ-1]];

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic ptr_reg;

    // After every accept the other requester becomes preferred.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg <= 1'b0;
        end else if (accept) begin
            ptr_reg <= ~cmd_next.id;
        end
    end

    assign ptr_sel = ptr_reg;
`else
    assign ptr_sel = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        req_ready_o = '0;
        accept      = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready_o = grant;
                if (|req_valid_i) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (resp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A reset edge wins over any handshake in the same cycle.
        if (rst_i) begin
            req_ready_o = '0;
            accept      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            cmd_reg       <= '0;
            resp_data_reg <= '0;
            resp_eq_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cmd_reg <= cmd_next;
            end
            if (state_reg == EXEC) begin
                resp_data_reg <= dp_alu_out_i;
                resp_eq_reg   <= dp_eq_i;
            end
        end
    end

    // Datapath fields always reflect the command register; only the write
    // enable is qualified, and reset gates it so an in-flight write is lost.
    assign dp_rs1_o           = cmd_reg.rs1;
    assign dp_rs2_o           = cmd_reg.rs2;
    assign dp_rd_o            = cmd_reg.rd;
    assign dp_imm_o           = cmd_reg.imm;
    assign dp_alu_src_o       = cmd_reg.alu_src;
    assign dp_alu_ctrl_o      = cmd_reg.alu_ctrl;
    assign dp_reg_write_o     = (state_reg == EXEC) && cmd_reg.reg_write && !rst_i;
    assign dp_reg_write_src_o = 1'b0;

    assign resp_valid_o = (state_reg == RESP) && !rst_i;
    assign resp_id_o    = cmd_reg.id;
    assign resp_data_o  = resp_data_reg;
    assign resp_eq_o    = resp_eq_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural register file and ALU
// stand in for the datapath, and a shadow register-file model predicts
// every result, grant and write-back.
module tb_alu_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [1:0]      req_valid_i, req_ready_o, req_alu_src_i, req_reg_write_i;
    logic [2*AW-1:0] req_rs1_i, req_rs2_i, req_rd_i;
    logic [2*DW-1:0] req_imm_i;
    logic [7:0]      req_alu_ctrl_i;
    logic [AW-1:0]   dp_rs1_o, dp_rs2_o, dp_rd_o;
    logic [DW-1:0]   dp_imm_o, dp_alu_out_i, resp_data_o;
    logic            dp_alu_src_o, dp_reg_write_o, dp_reg_write_src_o, dp_eq_i;
    logic [3:0]      dp_alu_ctrl_o;
    logic            resp_valid_o, resp_ready_i, resp_id_o, resp_eq_o;

    always #5 clk = ~clk;

    alu_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_rd_i(req_rd_i),
        .req_imm_i(req_imm_i), .req_alu_src_i(req_alu_src_i),
        .req_alu_ctrl_i(req_alu_ctrl_i), .req_reg_write_i(req_reg_write_i),
        .dp_rs1_o(dp_rs1_o), .dp_rs2_o(dp_rs2_o), .dp_rd_o(dp_rd_o),
        .dp_imm_o(dp_imm_o), .dp_alu_src_o(dp_alu_src_o), .dp_alu_ctrl_o(dp_alu_ctrl_o),
        .dp_reg_write_o(dp_reg_write_o), .dp_reg_write_src_o(dp_reg_write_src_o),
        .dp_alu_out_i(dp_alu_out_i), .dp_eq_i(dp_eq_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_id_o(resp_id_o), .resp_data_o(resp_data_o), .resp_eq_o(resp_eq_o)
    );

    function automatic logic [DW-1:0] alu_op(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a << b[4:0];
        endcase
    endfunction

    // Datapath environment: register file with a bench poke port.
    logic [DW-1:0] rf [32];
    logic [DW-1:0] op_a, op_b;
    logic          poke_en;
    logic [AW-1:0] poke_addr;
    logic [DW-1:0] poke_data;
    int            wr_count = 0;
    int            ready1_count = 0;

    always_comb begin
        op_a         = rf[dp_rs1_o];
        op_b         = dp_alu_src_o ? dp_imm_o : rf[dp_rs2_o];
        dp_alu_out_i = alu_op(dp_alu_ctrl_o, op_a, op_b);
        dp_eq_i      = (op_a == op_b);
    end

    always @(posedge clk) begin
        if (dp_reg_write_o) begin
            rf[dp_rd_o] <= dp_alu_out_i;
            wr_count    <= wr_count + 1;
        end else if (poke_en) begin
            rf[poke_addr] <= poke_data;
        end
    end

    always @(negedge clk) begin
        if (req_ready_o[1]) ready1_count <= ready1_count + 1;
    end

    // Reference model state and counters.
    logic [DW-1:0] model_rf [32];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic drive_req(input int id, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                             input logic [AW-1:0] rd, input logic [DW-1:0] imm, input logic src,
                             input logic [3:0] ctrl, input logic rw);
        req_rs1_i[id*AW +: AW]     = rs1;
        req_rs2_i[id*AW +: AW]     = rs2;
        req_rd_i[id*AW +: AW]      = rd;
        req_imm_i[id*DW +: DW]     = imm;
        req_alu_src_i[id]          = src;
        req_alu_ctrl_i[id*4 +: 4]  = ctrl;
        req_reg_write_i[id]        = rw;
    endtask

    task automatic poke(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        poke_en = 1'b1; poke_addr = addr; poke_data = data;
        model_rf[addr] = data;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Issues one command from requester id and checks the whole transaction.
    task automatic run_op(input int id, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [AW-1:0] rd, input logic [DW-1:0] imm, input logic src,
                          input logic [3:0] ctrl, input logic rw, input int bp, input string tag);
        logic [DW-1:0] a, b, exp_d, exp_rd;
        logic          exp_eq;
        logic [1:0]    exp_rdy;
        int            wc;
        a      = model_rf[rs1];
        b      = src ? imm : model_rf[rs2];
        exp_d  = alu_op(ctrl, a, b);
        exp_eq = (a == b);
        exp_rd = rw ? exp_d : model_rf[rd];
        exp_rdy = 2'b00;
        exp_rdy[id] = 1'b1;
        drive_req(id, rs1, rs2, rd, imm, src, ctrl, rw);
        req_valid_i = exp_rdy;
        #1;
        for (int t = 0; t < 8 && req_ready_o == 2'b00; t++) @(negedge clk);
        // cycle N: grant visible
        n_cmp++; if (req_ready_o !== exp_rdy) begin n_bad++; $display("FAIL %s.grant got %b expected %b", tag, req_ready_o, exp_rdy); end
        n_cmp++; if (dp_reg_write_o !== 1'b0) begin n_bad++; $display("FAIL %s.wr_at_N got %b expected 0", tag, dp_reg_write_o); end
        wc = wr_count;
        @(negedge clk);
        // cycle N+1: EXEC
        n_cmp++; if (dp_reg_write_o !== rw) begin n_bad++; $display("FAIL %s.wr_at_N+1 got %b expected %b", tag, dp_reg_write_o, rw); end
        n_cmp++; if (req_ready_o !== 2'b00) begin n_bad++; $display("FAIL %s.ready_exec got %b expected 00", tag, req_ready_o); end
        n_cmp++; if (resp_valid_o !== 1'b0) begin n_bad++; $display("FAIL %s.resp_early got %b expected 0", tag, resp_valid_o); end
        n_cmp++; if (dp_rd_o !== rd) begin n_bad++; $display("FAIL %s.dp_rd got %0d expected %0d", tag, dp_rd_o, rd); end
        req_valid_i = 2'b00;
        @(negedge clk);
        // cycle N+2: response
        n_cmp++; if (resp_valid_o !== 1'b1) begin n_bad++; $display("FAIL %s.resp_valid got %b expected 1", tag, resp_valid_o); end
        n_cmp++; if (resp_data_o !== exp_d) begin n_bad++; $display("FAIL %s.resp_data got %h expected %h", tag, resp_data_o, exp_d); end
        n_cmp++; if (resp_id_o !== 1'(id)) begin n_bad++; $display("FAIL %s.resp_id got %b expected %0d", tag, resp_id_o, id); end
        n_cmp++; if (resp_eq_o !== exp_eq) begin n_bad++; $display("FAIL %s.resp_eq got %b expected %b", tag, resp_eq_o, exp_eq); end
        n_cmp++; if (rf[rd] !== exp_rd) begin n_bad++; $display("FAIL %s.regfile got %h expected %h", tag, rf[rd], exp_rd); end
        n_cmp++; if (wr_count !== wc + int'(rw)) begin n_bad++; $display("FAIL %s.write_count got %0d expected %0d", tag, wr_count, wc + int'(rw)); end
        model_rf[rd] = exp_rd;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            n_cmp++;
            if (resp_valid_o !== 1'b1 || resp_data_o !== exp_d || resp_eq_o !== exp_eq
                || req_ready_o !== 2'b00 || dp_reg_write_o !== 1'b0 || wr_count !== wc + int'(rw)) begin
                n_bad++;
                $display("FAIL %s.hold%0d got v=%b d=%h rdy=%b wr=%b expected v=1 d=%h rdy=00 wr=0", tag, i,
                         resp_valid_o, resp_data_o, req_ready_o, dp_reg_write_o, exp_d);
            end
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        n_cmp++; if (resp_valid_o !== 1'b0) begin n_bad++; $display("FAIL %s.release got %b expected 0", tag, resp_valid_o); end
        $display("op %s: id=%0d ctrl=%0d rd=%0d rw=%b data=%h eq=%b bp=%0d", tag, id, ctrl, rd, rw, exp_d, exp_eq, bp);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_valid_i = 2'b11; resp_ready_i = 1'b0; poke_en = 1'b0;
        poke_addr = '0; poke_data = '0;
        req_rs1_i = '0; req_rs2_i = '0; req_rd_i = '0; req_imm_i = '0;
        req_alu_src_i = '0; req_alu_ctrl_i = '0; req_reg_write_i = 2'b11;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready_o !== 2'b00 || resp_valid_o !== 1'b0 || dp_reg_write_o !== 1'b0 || dp_rd_o !== '0 || resp_data_o !== '0) begin
                n_bad++;
                $display("FAIL reset.cycle%0d got rdy=%b v=%b wr=%b rd=%0d d=%h expected all zero", i,
                         req_ready_o, resp_valid_o, dp_reg_write_o, dp_rd_o, resp_data_o);
            end
        end
        n_cmp++; if (dp_reg_write_src_o !== 1'b0) begin n_bad++; $display("FAIL reset.wr_src got %b expected 0", dp_reg_write_src_o); end
        rst_i = 1'b0; req_valid_i = 2'b00;
        $display("reset: held 2 cycles with both requesters valid");
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) poke(AW'(i), $urandom);
    endtask

    task automatic test_contention();
        int exp_order [4];
        int gid;
        logic [DW-1:0] exp_d [2];
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        ready1_count = 0;
        drive_req(0, 5'd1, 5'd2, 5'd10, 32'h0, 1'b0, 4'd0, 1'b0);
        drive_req(1, 5'd3, 5'd0, 5'd11, 32'h00ff00ff, 1'b1, 4'd4, 1'b0);
        exp_d[0] = model_rf[1] + model_rf[2];
        exp_d[1] = model_rf[3] ^ 32'h00ff00ff;
        req_valid_i = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 8 && req_ready_o == 2'b00; t++) @(negedge clk);
            gid = req_ready_o[1] ? 1 : 0;
            n_cmp++;
            if (req_ready_o !== (2'b01 << exp_order[k])) begin
                n_bad++; $display("FAIL contention.grant%0d got %b expected requester %0d", k, req_ready_o, exp_order[k]);
            end
            @(negedge clk);
            @(negedge clk);
            n_cmp++;
            if (resp_valid_o !== 1'b1 || resp_id_o !== 1'(exp_order[k]) || resp_data_o !== exp_d[exp_order[k]]) begin
                n_bad++; $display("FAIL contention.resp%0d got v=%b id=%b d=%h expected v=1 id=%0d d=%h", k,
                                  resp_valid_o, resp_id_o, resp_data_o, exp_order[k], exp_d[exp_order[k]]);
            end
            resp_ready_i = 1'b1;
            @(negedge clk);
            resp_ready_i = 1'b0;
            $display("contention: op %0d granted requester %0d", k, gid);
        end
        req_valid_i = 2'b00;
`ifndef ALU_ARB_ROUND_ROBIN_EN
        n_cmp++; if (ready1_count !== 0) begin n_bad++; $display("FAIL contention.req1_ready got %0d cycles expected 0", ready1_count); end
`endif
    endtask

    task automatic test_single();
        poke(5'd1, 32'd5);
        poke(5'd2, 32'd7);
        run_op(0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 4'd0, 1'b1, 0, "single_add");
        n_cmp++; if (rf[3] !== 32'd12) begin n_bad++; $display("FAIL single.x3 got %0d expected 12", rf[3]); end
    endtask

    task automatic test_equal();
        poke(5'd4, 32'd9);
        poke(5'd5, 32'd9);
        run_op(1, 5'd4, 5'd5, 5'd7, 32'd0, 1'b0, 4'd1, 1'b0, 1, "equal_sub");
    endtask

    task automatic test_back_to_back();
        run_op(0, 5'd8, 5'd9, 5'd12, 32'd0, 1'b0, 4'd3, 1'b1, 5, "backpressure");
    endtask

    task automatic test_reset_exec();
        logic [DW-1:0] old;
        int wc;
        old = model_rf[6];
        drive_req(0, 5'd1, 5'd2, 5'd6, 32'd0, 1'b0, 4'd0, 1'b1);
        req_valid_i = 2'b01;
        #1;
        for (int t = 0; t < 8 && req_ready_o == 2'b00; t++) @(negedge clk);
        wc = wr_count;
        @(negedge clk);
        req_valid_i = 2'b00;
        rst_i = 1'b1;
        #1;
        n_cmp++; if (dp_reg_write_o !== 1'b0) begin n_bad++; $display("FAIL reset_exec.wr got %b expected 0", dp_reg_write_o); end
        @(negedge clk);
        rst_i = 1'b0;
        n_cmp++; if (rf[6] !== old || wr_count !== wc) begin n_bad++; $display("FAIL reset_exec.x6 got %h expected %h", rf[6], old); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (resp_valid_o !== 1'b0 || dp_rd_o !== '0) begin
                n_bad++; $display("FAIL reset_exec.cycle%0d got v=%b rd=%0d expected v=0 rd=0", i, resp_valid_o, dp_rd_o);
            end
        end
        $display("reset_exec: write to x6 suppressed, no response");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_op($urandom_range(0, 1), AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
                   AW'($urandom_range(1, 31)), $urandom, 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_contention();
        test_single();
        test_equal();
        test_back_to_back();
        test_reset_exec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
